packet_collector: RTL and testbench

- Receive end of the packet-slot shuffle: the transmit side steps a 4-bit slot index 0..DATA_PACKETS-1 and emits one packet word per step.
- This block accepts those words one at a time, aligns to the frame start, and writes each word into its slot.
- When all DATA_PACKETS slots are filled, it presents the complete frame in parallel with a one-cycle valid pulse.
- Sits between the word-level link receiver and the host-side readout logic.

---
 rtl/packet_collector_pkg.sv | 19 +
 rtl/packet_collector_gap_timer.sv | 40 ++++
 rtl/packet_collector.sv | 154 +++++++++++++++
 tb/tb_packet_collector.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_collector_pkg.sv
// -----------------------------------------------------------------------------
// packet_collector_pkg
// Shared definitions for the packet-slot shuffle. The transmit-side slot
// counter uses the same constants, so both ends agree on slot numbering.
//   SEL_WIDTH            width of the slot index carried on the link side
//   DEFAULT_DATA_PACKETS default number of words per frame
//   state_t              receive FSM state encoding
// -----------------------------------------------------------------------------
package packet_collector_pkg;

    localparam int SEL_WIDTH            = 4;
    localparam int DEFAULT_DATA_PACKETS = 10;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage : packet_collector_pkg

// File: rtl/packet_collector_gap_timer.sv
// -----------------------------------------------------------------------------
// gap_timer
// Counts idle cycles between accepted words and flags when the allowed gap
// has been used up.
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       forces the count back to zero (word accepted, or not in a frame)
//   enable      count this cycle
//   expired     count has reached TIMEOUT_CYCLES-1; the owner abandons the
//               frame on the next edge
// -----------------------------------------------------------------------------
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == LAST);

    // Saturates at LAST so the counter can never wrap while waiting for the
    // owner to react.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : gap_timer

// File: rtl/packet_collector.sv
// -----------------------------------------------------------------------------
// packet_collector
// Receive end of the packet-slot shuffle. Aligns to frame_start, writes each
// accepted word into its slot and publishes the full frame in parallel.
//   clk, rst_n   clock and asynchronous active-low reset
//   data_in      incoming packet word
//   data_valid   data_in is valid; one word accepted per high cycle
//   frame_start  marks data_in as slot 0 (only meaningful with data_valid)
//   selection    slot the next accepted word goes to
//   frame_out    last complete frame, slot k at [k*PACKET_WIDTH +: PACKET_WIDTH]
//   frame_valid  one-cycle pulse after frame_out was loaded
//   frame_err    one-cycle pulse on resync or gap timeout
//   busy         a frame is partially collected (state is COLLECT)
// -----------------------------------------------------------------------------
module packet_collector
    import packet_collector_pkg::*;
#(
    parameter int DATA_PACKETS   = DEFAULT_DATA_PACKETS,
    parameter int PACKET_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [PACKET_WIDTH-1:0]              data_in,
    input  logic                                 data_valid,
    input  logic                                 frame_start,
    output logic [SEL_WIDTH-1:0]                 selection,
    output logic [DATA_PACKETS*PACKET_WIDTH-1:0] frame_out,
    output logic                                 frame_valid,
    output logic                                 frame_err,
    output logic                                 busy
);

    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(DATA_PACKETS - 1);

    state_t                          state, state_nxt;
    logic [SEL_WIDTH-1:0]            sel, sel_nxt;
    logic                            wr_en;
    logic [SEL_WIDTH-1:0]            wr_idx;
    logic                            complete;
    logic                            err_nxt;
    logic                            expired;
    logic [PACKET_WIDTH-1:0]         shadow [DATA_PACKETS];
    logic [DATA_PACKETS*PACKET_WIDTH-1:0] frame_next;

    assign selection = sel;
    assign busy      = (state == COLLECT);

    // Timer only runs while a frame is open and the link is idle; any
    // accepted word restarts the gap measurement.
    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (data_valid || (state == HUNT)),
        .enable ((state == COLLECT) && !data_valid),
        .expired(expired)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        wr_en     = 1'b0;
        wr_idx    = sel;
        complete  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            HUNT: begin
                // Words without frame_start are dropped silently here.
                if (data_valid && frame_start) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    if (DATA_PACKETS == 1) begin
                        complete = 1'b1;
                    end else begin
                        sel_nxt   = SEL_WIDTH'(1);
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                // An accepted word always beats a timer expiring on the same edge.
                if (data_valid) begin
                    wr_en = 1'b1;
                    if (frame_start) begin
                        err_nxt = 1'b1;
                        wr_idx  = '0;
                        sel_nxt = SEL_WIDTH'(1);
                    end else if (sel == LAST_SEL) begin
                        complete  = 1'b1;
                        sel_nxt   = '0;
                        state_nxt = HUNT;
                    end else begin
                        sel_nxt = sel + 1'b1;
                    end
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    sel_nxt   = '0;
                    state_nxt = HUNT;
                end
            end
            default: begin
                state_nxt = HUNT;
                sel_nxt   = '0;
            end
        endcase
    end

    // Completed frame: shadow slots with the word arriving now in the last slot.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < DATA_PACKETS; k++) begin
            if (k == DATA_PACKETS - 1) begin
                frame_next[k*PACKET_WIDTH +: PACKET_WIDTH] = data_in;
            end else begin
                frame_next[k*PACKET_WIDTH +: PACKET_WIDTH] = shadow[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            sel         <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            frame_valid <= complete;
            frame_err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_out <= '0;
            for (int k = 0; k < DATA_PACKETS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DATA_PACKETS; k++) begin
                if (wr_en && (wr_idx == SEL_WIDTH'(k))) begin
                    shadow[k] <= data_in;
                end
            end
            if (complete) begin
                frame_out <= frame_next;
            end
        end
    end

endmodule : packet_collector

// File: tb/tb_packet_collector.sv
// -----------------------------------------------------------------------------
// tb_packet_collector
// Directed bench for packet_collector (10 slots, 32-bit words, 16-cycle gap
// timeout). Inputs change on the falling edge; outputs are sampled on the
// falling edge. A monitor compares every frame_valid against an expected
// frame queue.
// -----------------------------------------------------------------------------
module tb_packet_collector;

    localparam int DP = 10;
    localparam int PW = 32;
    localparam int TO = 16;
    localparam int FW = DP * PW;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] data_in;
    logic          data_valid;
    logic          frame_start;
    logic [3:0]    selection;
    logic [FW-1:0] frame_out;
    logic          frame_valid;
    logic          frame_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int fe_cnt   = 0;

    logic [FW-1:0] exp_q[$];

    packet_collector #(
        .DATA_PACKETS  (DP),
        .PACKET_WIDTH  (PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .frame_start(frame_start),
        .selection  (selection),
        .frame_out  (frame_out),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] make_frame(input logic [PW-1:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < DP; k++) f[k*PW +: PW] = base + PW'(k);
        return f;
    endfunction

    // Present one word for one cycle; returns on the falling edge after the
    // rising edge that accepted it.
    task automatic send(input logic [PW-1:0] d, input logic fs);
        data_in     = d;
        data_valid  = 1'b1;
        frame_start = fs;
        @(negedge clk);
        data_valid  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [PW-1:0] base);
        for (int k = 0; k < DP; k++) send(base + PW'(k), (k == 0));
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            assert (!(frame_valid && frame_err)) else begin
                n_fail++;
                $error("FAIL valid_err_overlap: observed both high expected exclusive");
            end
            if (frame_err) fe_cnt++;
            if (frame_valid) begin
                fv_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $error("FAIL unexpected_frame: observed frame_valid expected none, frame %0h", frame_out);
                end else begin
                    logic [FW-1:0] e;
                    e = exp_q.pop_front();
                    assert (frame_out === e) else begin
                        n_fail++;
                        $error("FAIL frame_data: observed %0h expected %0h", frame_out, e);
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int fv0, fe0;
        logic early_err;

        rst_n       = 1'b0;
        data_in     = '0;
        data_valid  = 1'b0;
        frame_start = 1'b0;
        idle(3);
        check("rst_selection", FW'(selection), FW'(0));
        check("rst_busy", FW'(busy), FW'(0));
        check("rst_frame_valid", FW'(frame_valid), FW'(0));
        check("rst_frame_err", FW'(frame_err), FW'(0));
        check("rst_frame_out", frame_out, '0);
        rst_n = 1'b1;
        idle(2);

        // Clean frame 0x100..0x109 on consecutive cycles
        fv0 = fv_cnt; fe0 = fe_cnt;
        exp_q.push_back(make_frame(32'h100));
        send_frame(32'h100);
        check("clean_valid", FW'(frame_valid), FW'(1));
        check("clean_selection", FW'(selection), FW'(0));
        check("clean_busy", FW'(busy), FW'(0));
        for (int k = 0; k < DP; k++)
            check($sformatf("clean_slot%0d", k), FW'(frame_out[k*PW +: PW]), FW'(32'h100 + k));
        idle(1);
        check("clean_valid_pulse", FW'(frame_valid), FW'(0));
        check("clean_fv_count", FW'(fv_cnt - fv0), FW'(1));
        check("clean_fe_count", FW'(fe_cnt - fe0), FW'(0));

        // Sparse words, 5 cycles apart
        fv0 = fv_cnt; fe0 = fe_cnt;
        exp_q.push_back(make_frame(32'h200));
        for (int k = 0; k < DP; k++) begin
            check($sformatf("sparse_sel%0d", k), FW'(selection), FW'(k));
            send(32'h200 + PW'(k), (k == 0));
            if (k != DP - 1) idle(4);
        end
        idle(2);
        check("sparse_fv_count", FW'(fv_cnt - fv0), FW'(1));
        check("sparse_fe_count", FW'(fe_cnt - fe0), FW'(0));

        // Unaligned entry: three words without frame_start are dropped
        fv0 = fv_cnt; fe0 = fe_cnt;
        send(32'h55, 1'b0); send(32'h56, 1'b0); send(32'h57, 1'b0);
        check("unaligned_sel", FW'(selection), FW'(0));
        check("unaligned_busy", FW'(busy), FW'(0));
        exp_q.push_back(make_frame(32'hA0));
        send_frame(32'hA0);
        idle(1);
        check("unaligned_slot0", FW'(frame_out[PW-1:0]), FW'(32'hA0));
        check("unaligned_fv_count", FW'(fv_cnt - fv0), FW'(1));
        check("unaligned_fe_count", FW'(fe_cnt - fe0), FW'(0));

        // Resync after four words
        fv0 = fv_cnt; fe0 = fe_cnt;
        for (int k = 1; k <= 4; k++) send(PW'(k), (k == 1));
        check("resync_pre_sel", FW'(selection), FW'(4));
        check("resync_pre_busy", FW'(busy), FW'(1));
        exp_q.push_back(make_frame(32'h20));
        send(32'h20, 1'b1);
        check("resync_err", FW'(frame_err), FW'(1));
        check("resync_sel", FW'(selection), FW'(1));
        check("resync_busy", FW'(busy), FW'(1));
        check("resync_frame_hold", frame_out, make_frame(32'hA0));
        for (int k = 1; k < DP; k++) send(32'h20 + PW'(k), 1'b0);
        check("resync_valid", FW'(frame_valid), FW'(1));
        idle(1);
        check("resync_frame", frame_out, make_frame(32'h20));
        check("resync_fe_count", FW'(fe_cnt - fe0), FW'(1));
        check("resync_fv_count", FW'(fv_cnt - fv0), FW'(1));

        // Timeout: six words then silence
        fv0 = fv_cnt; fe0 = fe_cnt;
        for (int k = 0; k < 6; k++) send(32'h30 + PW'(k), (k == 0));
        early_err = 1'b0;
        for (int i = 1; i < TO; i++) begin
            idle(1);
            if (frame_err) early_err = 1'b1;
        end
        check("timeout_no_early_err", FW'(early_err), FW'(0));
        check("timeout_pre_busy", FW'(busy), FW'(1));
        check("timeout_pre_sel", FW'(selection), FW'(6));
        idle(1);
        check("timeout_err", FW'(frame_err), FW'(1));
        check("timeout_sel", FW'(selection), FW'(0));
        check("timeout_busy", FW'(busy), FW'(0));
        check("timeout_frame_hold", frame_out, make_frame(32'h20));
        idle(1);
        check("timeout_err_pulse", FW'(frame_err), FW'(0));
        check("timeout_fe_count", FW'(fe_cnt - fe0), FW'(1));
        check("timeout_fv_count", FW'(fv_cnt - fv0), FW'(0));

        // Reset mid-frame
        fv0 = fv_cnt;
        for (int k = 0; k < 5; k++) send(32'h40 + PW'(k), (k == 0));
        rst_n = 1'b0;
        #1;
        check("midrst_frame_out", frame_out, '0);
        check("midrst_sel", FW'(selection), FW'(0));
        check("midrst_busy", FW'(busy), FW'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("midrst_fv_count", FW'(fv_cnt - fv0), FW'(0));
        exp_q.push_back(make_frame(32'hC0));
        send_frame(32'hC0);
        check("post_rst_valid", FW'(frame_valid), FW'(1));
        idle(2);
        check("post_rst_frame", frame_out, make_frame(32'hC0));
        check("exp_q_drained", FW'(exp_q.size()), FW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_packet_collector
